time_set_ctrl: RTL and testbench



---
 rtl/clock_pkg.sv | 34 +++
 rtl/button_debounce.sv | 46 ++++
 rtl/time_set_ctrl.sv | 140 ++++++++++++++
 tb/tb_time_set_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants, digit limit helper and FSM state type for the clock editing front-end.
package clock_pkg;

  localparam logic [2:0] DIG_S1 = 3'd0;
  localparam logic [2:0] DIG_S2 = 3'd1;
  localparam logic [2:0] DIG_M1 = 3'd2;
  localparam logic [2:0] DIG_M2 = 3'd3;
  localparam logic [2:0] DIG_H1 = 3'd4;
  localparam logic [2:0] DIG_H2 = 3'd5;

  localparam logic [3:0] LIM_S1     = 4'd9;
  localparam logic [3:0] LIM_S2     = 4'd5;
  localparam logic [3:0] LIM_M1     = 4'd9;
  localparam logic [3:0] LIM_M2     = 4'd5;
  localparam logic [3:0] LIM_H1     = 4'd9;
  localparam logic [3:0] LIM_H1_H22 = 4'd3;
  localparam logic [3:0] LIM_H2     = 4'd2;

  typedef enum logic {RUN, EDIT} state_e;

  // Effective upper bound of a digit; h1 tightens to 3 in the 20-23 hour range.
  function automatic logic [3:0] digit_limit(input logic [2:0] idx, input logic [3:0] h2);
    case (idx)
      DIG_S1:  return LIM_S1;
      DIG_S2:  return LIM_S2;
      DIG_M1:  return LIM_M1;
      DIG_M2:  return LIM_M2;
      DIG_H1:  return (h2 == LIM_H2) ? LIM_H1_H22 : LIM_H1;
      DIG_H2:  return LIM_H2;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one active-low button; emits a 1-cycle pulse on each press.
module button_debounce #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam int unsigned   CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q, level_q, level_d1_q, press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      level_q    <= 1'b1;
      level_d1_q <= 1'b1;
      press_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      sync1_q    <= btn_n;
      sync2_q    <= sync1_q;
      level_d1_q <= level_q;
      press_q    <= level_d1_q & ~level_q;
      // Any sample matching the current level restarts the stability window.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/time_set_ctrl.sv
// RUN/EDIT front-end: debounced buttons select and adjust BCD digits, then load the clock core.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 12000000,
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned BLINK_DIV   = 6000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b1,
  input  logic       b2,
  input  logic       b3,
  input  logic       b4,
  input  logic [3:0] cur_h2,
  input  logic [3:0] cur_h1,
  input  logic [3:0] cur_m2,
  input  logic [3:0] cur_m1,
  input  logic [3:0] cur_s2,
  input  logic [3:0] cur_s1,
  output logic [3:0] set_h2,
  output logic [3:0] set_h1,
  output logic [3:0] set_m2,
  output logic [3:0] set_m1,
  output logic [3:0] set_s2,
  output logic [3:0] set_s1,
  output logic       load,
  output logic       edit_mode,
  output logic [2:0] sel,
  output logic       blank
);

  localparam int unsigned   DEB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned   BW         = $clog2(BLINK_DIV);
  localparam logic [BW-1:0] BLINK_MAX  = BW'(BLINK_DIV - 1);

  logic [3:0] btn_n, lvl, prs;
  assign btn_n = {b4, b3, b2, b1};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .btn_n (btn_n[i]),
      .level (lvl[i]),
      .press (prs[i])
    );
  end

  state_e             state_q, state_d;
  logic [5:0][3:0]    dig_q, dig_d;
  logic [2:0]         sel_q, sel_d;
  logic               load_q, load_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic               phase_q, phase_d;
  logic [3:0]         cap_h2, sel_dig, sel_lim;

  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    sel_d   = sel_q;
    load_d  = 1'b0;
    bcnt_d  = '0;
    phase_d = 1'b0;
    cap_h2  = (cur_h2 > LIM_H2) ? 4'd0 : cur_h2;
    sel_dig = dig_q[sel_q];
    sel_lim = digit_limit(sel_q, dig_q[DIG_H2]);

    unique case (state_q)
      RUN: begin
        if (prs[0]) begin
          state_d        = EDIT;
          sel_d          = DIG_S1;
          dig_d[DIG_S1]  = (cur_s1 > LIM_S1) ? 4'd0 : cur_s1;
          dig_d[DIG_S2]  = (cur_s2 > LIM_S2) ? 4'd0 : cur_s2;
          dig_d[DIG_M1]  = (cur_m1 > LIM_M1) ? 4'd0 : cur_m1;
          dig_d[DIG_M2]  = (cur_m2 > LIM_M2) ? 4'd0 : cur_m2;
          dig_d[DIG_H2]  = cap_h2;
          dig_d[DIG_H1]  = (cur_h1 > digit_limit(DIG_H1, cap_h2)) ? 4'd0 : cur_h1;
        end
      end
      EDIT: begin
        // Free-running blink unless an action below restarts it.
        if (bcnt_q == BLINK_MAX) begin
          phase_d = ~phase_q;
        end else begin
          bcnt_d  = bcnt_q + 1'b1;
          phase_d = phase_q;
        end
        if (prs[0]) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (prs[1]) begin
          sel_d   = (sel_q == DIG_H2) ? DIG_S1 : sel_q + 3'd1;
          bcnt_d  = '0;
          phase_d = 1'b0;
        end else if (prs[2] || prs[3]) begin
          if (prs[2]) dig_d[sel_q] = (sel_dig >= sel_lim) ? 4'd0 : sel_dig + 4'd1;
          else        dig_d[sel_q] = (sel_dig == 4'd0) ? sel_lim : sel_dig - 4'd1;
          if (sel_q == DIG_H2 && dig_d[DIG_H2] == LIM_H2 && dig_d[DIG_H1] > LIM_H1_H22) begin
            dig_d[DIG_H1] = LIM_H1_H22;
          end
          bcnt_d  = '0;
          phase_d = 1'b0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      dig_q   <= '0;
      sel_q   <= '0;
      load_q  <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign set_s1    = dig_q[DIG_S1];
  assign set_s2    = dig_q[DIG_S2];
  assign set_m1    = dig_q[DIG_M1];
  assign set_m2    = dig_q[DIG_M2];
  assign set_h1    = dig_q[DIG_H1];
  assign set_h2    = dig_q[DIG_H2];
  assign load      = load_q;
  assign edit_mode = (state_q == EDIT);
  assign sel       = sel_q;
  assign blank     = edit_mode & phase_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl with DEB_CYCLES = 4 and BLINK_DIV = 8.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] bn  = 4'hF;
  logic [3:0] cur_h2 = '0, cur_h1 = '0, cur_m2 = '0, cur_m1 = '0, cur_s2 = '0, cur_s1 = '0;
  logic [3:0] set_h2, set_h1, set_m2, set_m1, set_s2, set_s1;
  logic       load, edit_mode, blank;
  logic [2:0] sel;
  int         n_vec = 0;
  int         n_err = 0;
  int         load_cycles = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.CLK_HZ(4000), .DEBOUNCE_MS(1), .BLINK_DIV(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .b1        (bn[0]),
    .b2        (bn[1]),
    .b3        (bn[2]),
    .b4        (bn[3]),
    .cur_h2    (cur_h2),
    .cur_h1    (cur_h1),
    .cur_m2    (cur_m2),
    .cur_m1    (cur_m1),
    .cur_s2    (cur_s2),
    .cur_s1    (cur_s1),
    .set_h2    (set_h2),
    .set_h1    (set_h1),
    .set_m2    (set_m2),
    .set_m1    (set_m1),
    .set_s2    (set_s2),
    .set_s1    (set_s1),
    .load      (load),
    .edit_mode (edit_mode),
    .sel       (sel),
    .blank     (blank)
  );

  logic [23:0] set_all;
  assign set_all = {set_h2, set_h1, set_m2, set_m1, set_s2, set_s1};

  always @(posedge clk) if (load) load_cycles <= load_cycles + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mask bit 0 = b1 ... bit 3 = b4
  task automatic press(input logic [3:0] mask);
    bn = ~mask;
    tick(10);
    bn = 4'hF;
    tick(14);
  endtask

  task automatic set_cur(input logic [23:0] t);
    {cur_h2, cur_h1, cur_m2, cur_m1, cur_s2, cur_s1} = t;
  endtask

  initial begin
    logic [2:0] old_sel;
    bit         found;
    int         load_hits;

    set_cur(24'h123456);
    tick(3);
    rst = 1'b0;
    check("rst_edit", edit_mode, 0);
    check("rst_sel", sel, 0);
    check("rst_load", load, 0);
    check("rst_blank", blank, 0);
    check("rst_set", set_all, 0);
    tick(8);
    check("rst_no_event", edit_mode, 0);

    // Short b1 bounces must not register.
    for (int i = 0; i < 4; i++) begin
      bn = 4'hE;
      tick(3);
      bn = 4'hF;
      tick(3);
    end
    tick(15);
    check("bounce_edit", edit_mode, 0);
    check("bounce_set", set_all, 0);

    press(4'b0001);
    check("enter_edit", edit_mode, 1);
    check("enter_sel", sel, 0);
    check("enter_set", set_all, 24'h123456);
    check("enter_load", load, 0);
    set_cur(24'h000000);

    repeat (3) press(4'b0100);
    check("s1_to9", set_all, 24'h123459);
    press(4'b0100);
    check("s1_wrap", set_all, 24'h123450);
    press(4'b0010);
    check("sel1", sel, 1);
    press(4'b0100);
    check("s2_wrap_up", set_all, 24'h123400);
    press(4'b1000);
    check("s2_wrap_dn", set_all, 24'h123450);

    repeat (3) press(4'b0010);
    check("sel4", sel, 4);
    repeat (3) press(4'b1000);
    check("h1_wrap_dn", set_all, 24'h193450);
    press(4'b0010);
    check("sel5", sel, 5);
    press(4'b0100);
    check("h2_clamp", set_all, 24'h233450);
    press(4'b0100);
    check("h2_wrap", set_all, 24'h033450);
    press(4'b0010);
    check("sel_wrap", sel, 0);
    repeat (6) press(4'b0010);
    check("sel_six", sel, 0);

    press(4'b0110);
    check("prio_sel", sel, 1);
    check("prio_set", set_all, 24'h033450);

    // Hold b2 and locate the action edge, then watch the blink from a cleared counter.
    old_sel = sel;
    found   = 1'b0;
    bn      = 4'hD;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1);
      if (sel != old_sel) found = 1'b1;
    end
    check("blink_sync", found, 1);
    check("blink_sel", sel, 2);
    for (int i = 0; i < 24; i++) begin
      check("blank", blank, (i / 8) % 2);
      tick(1);
    end
    bn = 4'hF;
    tick(14);
    check("hold_once", sel, 2);

    load_hits = 0;
    bn = 4'hE;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (load) begin
        load_hits++;
        check("load_edit", edit_mode, 0);
        check("load_set", set_all, 24'h033450);
      end
    end
    bn = 4'hF;
    tick(14);
    check("load_width", load_hits, 1);
    check("exit_edit", edit_mode, 0);
    check("exit_blank", blank, 0);
    check("exit_set", set_all, 24'h033450);

    press(4'b0100);
    check("run_ignore", set_all, 24'h033450);

    set_cur(24'h24697A);
    press(4'b0001);
    check("sanitize", set_all, 24'h200900);
    check("reenter_sel", sel, 0);
    check("reenter_edit", edit_mode, 1);

    rst = 1'b1;
    tick(1);
    check("mid_rst_edit", edit_mode, 0);
    check("mid_rst_set", set_all, 0);
    check("mid_rst_load", load, 0);
    check("mid_rst_blank", blank, 0);
    rst = 1'b0;
    tick(4);
    check("load_total", load_cycles, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
